calc_cmd_sequencer: RTL and testbench

CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

---
 rtl/calc_cmd_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Keypad command sequencer: replays a latched BCD request to the calculator as
// keystrokes, then follows the busy/ready handshake to capture the result.
module calc_cmd_sequencer #(
    parameter int unsigned TIMEOUT    = 127,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a_bcd,
    input  logic [3:0]  op_a_len,
    input  logic [31:0] op_b_bcd,
    input  logic [3:0]  op_b_len,
    input  logic [1:0]  op,
    input  logic [1:0]  status,
    input  logic [31:0] result,
    output logic [3:0]  cmd,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result_q
);

    localparam int unsigned CNT_W = (TIMEOUT >= 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);

    localparam logic [3:0] CMD_ADD = 4'hA;
    localparam logic [3:0] CMD_SUB = 4'hB;
    localparam logic [3:0] CMD_MUL = 4'hC;
    localparam logic [3:0] CMD_NOP = 4'hD;
    localparam logic [3:0] CMD_EQ  = 4'hE;
    localparam logic [3:0] CMD_CLR = 4'hF;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_SEND_A,
        S_SEND_OP,
        S_SEND_B,
        S_SEND_EQ,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t           state;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [3:0]       a_len_q;
    logic [3:0]       b_len_q;
    logic [1:0]       op_q;
    logic [2:0]       idx;
    logic [CNT_W-1:0] wait_cnt;

    logic req_ok_c;
    logic advance_c;
    logic fault_c;

    function automatic logic [3:0] digit_at(input logic [31:0] bcd, input logic [2:0] i);
        return bcd[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] op_code(input logic [1:0] o);
        case (o)
            2'b00:   return CMD_ADD;
            2'b01:   return CMD_SUB;
            default: return CMD_MUL;
        endcase
    endfunction

    // Request validation, handshake progress and abort conditions (calculator error or timeout)
    always_comb begin
        req_ok_c  = (op_a_len != 4'd0) && (op_a_len <= MAX_LEN) &&
                    (op_b_len != 4'd0) && (op_b_len <= MAX_LEN) && (op != 2'b11);
        advance_c = ((state == S_WAIT_BUSY) && (status == ST_BUSY)) ||
                    ((state == S_WAIT_DONE) && (status == ST_READY));
        fault_c   = 1'b0;
        if ((state != S_IDLE) && (state != S_DONE) && (status == ST_ERR)) begin
            fault_c = 1'b1;
        end
        if (((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) &&
            (wait_cnt == CNT_LAST) && !advance_c) begin
            fault_c = 1'b1;
        end
    end

    // Sequencer FSM; cmd is registered so it always reflects the state just entered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cmd      <= CMD_NOP;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            result_q <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            a_len_q  <= 4'd0;
            b_len_q  <= 4'd0;
            op_q     <= 2'b00;
            idx      <= 3'd0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (fault_c) begin
                // Abort: one CLR keystroke while already back in IDLE
                state    <= S_IDLE;
                cmd      <= CMD_CLR;
                busy     <= 1'b0;
                error    <= 1'b1;
                idx      <= 3'd0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cmd <= CMD_NOP;
                        if (start) begin
                            if (req_ok_c) begin
                                a_q     <= op_a_bcd;
                                b_q     <= op_b_bcd;
                                a_len_q <= op_a_len;
                                b_len_q <= op_b_len;
                                op_q    <= op;
                                error   <= 1'b0;
                                busy    <= 1'b1;
                                cmd     <= CMD_CLR;
                                state   <= S_CLR;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_CLR: begin
                        idx   <= 3'(a_len_q - 4'd1);
                        cmd   <= digit_at(a_q, 3'(a_len_q - 4'd1));
                        state <= S_SEND_A;
                    end
                    S_SEND_A: begin
                        if (idx == 3'd0) begin
                            cmd   <= op_code(op_q);
                            state <= S_SEND_OP;
                        end else begin
                            idx <= idx - 3'd1;
                            cmd <= digit_at(a_q, idx - 3'd1);
                        end
                    end
                    S_SEND_OP: begin
                        idx   <= 3'(b_len_q - 4'd1);
                        cmd   <= digit_at(b_q, 3'(b_len_q - 4'd1));
                        state <= S_SEND_B;
                    end
                    S_SEND_B: begin
                        if (idx == 3'd0) begin
                            cmd   <= CMD_EQ;
                            state <= S_SEND_EQ;
                        end else begin
                            idx <= idx - 3'd1;
                            cmd <= digit_at(b_q, idx - 3'd1);
                        end
                    end
                    S_SEND_EQ: begin
                        cmd      <= CMD_NOP;
                        wait_cnt <= '0;
                        state    <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        cmd <= CMD_NOP;
                        if (advance_c) begin
                            wait_cnt <= '0;
                            state    <= S_WAIT_DONE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    S_WAIT_DONE: begin
                        cmd <= CMD_NOP;
                        if (advance_c) begin
                            result_q <= result;
                            done     <= 1'b1;
                            wait_cnt <= '0;
                            state    <= S_DONE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        cmd   <= CMD_NOP;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        cmd   <= CMD_NOP;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: a keystroke-driven calculator model answers the
// sequencer; directed table, randomized requests and reset corner cases are checked.
module tb_calc_cmd_sequencer;

    localparam int unsigned TIMEOUT    = 127;
    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [3:0]  CMD_NOP    = 4'hD;
    localparam logic [3:0]  CMD_EQ     = 4'hE;
    localparam logic [3:0]  CMD_CLR    = 4'hF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a_bcd = 32'd0;
    logic [3:0]  op_a_len = 4'd0;
    logic [31:0] op_b_bcd = 32'd0;
    logic [3:0]  op_b_len = 4'd0;
    logic [1:0]  op = 2'b00;
    logic [1:0]  status = 2'b00;
    logic [31:0] result = 32'd0;
    logic [3:0]  cmd;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result_q;

    int checks = 0;
    int failures = 0;

    calc_cmd_sequencer #(.TIMEOUT(TIMEOUT), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clock(clock), .reset(reset), .start(start),
        .op_a_bcd(op_a_bcd), .op_a_len(op_a_len),
        .op_b_bcd(op_b_bcd), .op_b_len(op_b_len),
        .op(op), .status(status), .result(result),
        .cmd(cmd), .busy(busy), .done(done), .error(error), .result_q(result_q)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Calculator model: modes 0 normal, 1 raises error after busy, 2 never goes busy
    int          model_mode = 0;
    int          model_busy_len = 1;
    int unsigned m_acc = 0;
    int unsigned m_lhs = 0;
    int unsigned m_val = 0;
    logic [3:0]  m_opr = 4'hA;
    int          m_phase = 0;
    int          m_cnt = 0;

    function automatic logic [31:0] arith(input logic [31:0] l, input logic [31:0] r, input logic [1:0] o);
        case (o)
            2'b00:   return l + r;
            2'b01:   return l - r;
            default: return l * r;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            status  = 2'b00;
            m_phase = 0;
            m_acc   = 0;
        end else if (cmd == CMD_CLR) begin
            status  = 2'b00;
            m_phase = 0;
            m_acc   = 0;
            m_lhs   = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (cmd <= 4'd9) begin
                        m_acc = m_acc * 10 + 32'(cmd);
                    end else if (cmd >= 4'hA && cmd <= 4'hC) begin
                        m_lhs = m_acc;
                        m_acc = 0;
                        m_opr = cmd;
                    end else if (cmd == CMD_EQ) begin
                        m_val   = arith(m_lhs, m_acc, 2'(m_opr - 4'hA));
                        m_phase = 1;
                        m_cnt   = 2;
                    end
                end
                1: begin
                    if (model_mode != 2) begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            status  = 2'b01;
                            result  = 32'hDEAD_BEEF;
                            m_cnt   = model_busy_len;
                            m_phase = 2;
                        end
                    end
                end
                2: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        if (model_mode == 1) begin
                            status  = 2'b10;
                            m_phase = 3;
                        end else begin
                            status  = 2'b00;
                            result  = m_val;
                            m_phase = 0;
                        end
                    end
                end
                default: begin
                    status  = 2'b00;
                    m_phase = 0;
                end
            endcase
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [3:0]  alen;
        logic [31:0] b;
        logic [3:0]  blen;
        logic [1:0]  op;
        int          mode;
        int          busy_len;
        logic        exp_err;
        logic [31:0] exp_res;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [3:0] al, input logic [31:0] b,
                                input logic [3:0] bl, input logic [1:0] o, input int mode,
                                input int bn, input logic ee, input logic [31:0] er);
        vec_t v;
        v.a = a; v.alen = al; v.b = b; v.blen = bl; v.op = o;
        v.mode = mode; v.busy_len = bn; v.exp_err = ee; v.exp_res = er;
        return v;
    endfunction

    function automatic logic [31:0] bcd_val(input logic [31:0] bcd, input logic [3:0] len);
        logic [31:0] v = 32'd0;
        for (int i = int'(len) - 1; i >= 0; i--) v = v * 10 + 32'(bcd[i*4 +: 4]);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit poke);
        logic [3:0] seq[$];
        logic [3:0] exp[$];
        int         e_idx = -1;
        int         end_idx = -1;
        int         done_cnt = 0;
        int         mism = 0;
        logic [3:0] cmd_end = 4'h0;
        model_mode = v.mode;
        model_busy_len = v.busy_len;
        op_a_bcd = v.a; op_a_len = v.alen; op_b_bcd = v.b; op_b_len = v.blen; op = v.op;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (v.exp_err && v.mode == 0) begin
            int loud = 0;
            check("rej_error", 32'(error), 32'd1);
            for (int i = 0; i < 6; i++) begin
                if (busy || cmd != CMD_NOP) loud++;
                @(negedge clock);
            end
            check("rej_quiet", 32'(loud), 32'd0);
            check("rej_result", result_q, v.exp_res);
            return;
        end
        for (int i = 0; i < 800; i++) begin
            if (i == 0) begin
                check("busy_rise", 32'(busy), 32'd1);
                check("err_clear", 32'(error), 32'd0);
            end
            if (e_idx < 0) begin
                seq.push_back(cmd);
                if (cmd == CMD_EQ) e_idx = i;
            end
            if (done) done_cnt++;
            if (poke && i == 3) begin
                start = 1'b1;
                op_a_bcd = $urandom;
                op_a_len = 4'($urandom_range(0, 15));
                op = 2'($urandom);
            end
            if (poke && i == 4) start = 1'b0;
            if (!busy) begin
                end_idx = i;
                cmd_end = cmd;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("finished", 32'(end_idx >= 0), 32'd1);
        exp.push_back(CMD_CLR);
        for (int i = int'(v.alen) - 1; i >= 0; i--) exp.push_back(v.a[i*4 +: 4]);
        exp.push_back(4'hA + {2'b00, v.op});
        for (int i = int'(v.blen) - 1; i >= 0; i--) exp.push_back(v.b[i*4 +: 4]);
        exp.push_back(CMD_EQ);
        if (seq.size() != exp.size()) mism = 1;
        else foreach (exp[k]) if (seq[k] !== exp[k]) mism++;
        check("cmd_seq", 32'(mism), 32'd0);
        check("eq_cycle", 32'(e_idx + 1), 32'(3 + int'(v.alen) + int'(v.blen)));
        check("result_q", result_q, v.exp_res);
        if (v.mode == 0) begin
            check("done_once", 32'(done_cnt), 32'd1);
            check("no_error", 32'(error), 32'd0);
            check("idle_cmd", 32'(cmd_end), 32'(CMD_NOP));
        end else begin
            check("done_none", 32'(done_cnt), 32'd0);
            check("abort_err", 32'(error), 32'd1);
            check("abort_clr", 32'(cmd_end), 32'(CMD_CLR));
            if (v.mode == 2) check("timeout_len", 32'(end_idx - e_idx), 32'(TIMEOUT + 1));
            @(negedge clock);
            check("clr_once", 32'(cmd), 32'(CMD_NOP));
        end
    endtask

    vec_t tbl[12];

    initial begin
        repeat (3) @(negedge clock);
        check("rst_cmd", 32'(cmd), 32'(CMD_NOP));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_result", result_q, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        tbl[0]  = mk(32'h12, 4'd2, 32'h34, 4'd2, 2'b00, 0, 6, 1'b0, 32'd46);
        tbl[1]  = mk(32'h50, 4'd2, 32'h15, 4'd2, 2'b01, 0, 4, 1'b0, 32'd35);
        tbl[2]  = mk(32'h7, 4'd1, 32'h8, 4'd1, 2'b10, 0, 42, 1'b0, 32'd56);
        tbl[3]  = mk(32'h12345678, 4'd9, 32'h1, 4'd1, 2'b00, 0, 1, 1'b1, 32'd56);
        tbl[4]  = mk(32'h3, 4'd1, 32'h4, 4'd1, 2'b00, 0, 2, 1'b0, 32'd7);
        tbl[5]  = mk(32'h3, 4'd0, 32'h4, 4'd1, 2'b00, 0, 1, 1'b1, 32'd7);
        tbl[6]  = mk(32'h3, 4'd1, 32'h4, 4'd1, 2'b11, 0, 1, 1'b1, 32'd7);
        tbl[7]  = mk(32'h3, 4'd1, 32'h4, 4'd9, 2'b00, 0, 1, 1'b1, 32'd7);
        tbl[8]  = mk(32'h12345678, 4'd8, 32'h87654321, 4'd8, 2'b00, 0, 10, 1'b0, 32'd99999999);
        tbl[9]  = mk(32'h9, 4'd1, 32'h9, 4'd1, 2'b10, 1, 5, 1'b1, 32'd99999999);
        tbl[10] = mk(32'h1, 4'd1, 32'h2, 4'd1, 2'b01, 0, 3, 1'b0, 32'hFFFF_FFFF);
        tbl[11] = mk(32'h5, 4'd1, 32'h5, 4'd1, 2'b00, 2, 1, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0);

        for (int n = 0; n < 20; n++) begin
            vec_t v;
            v.alen = 4'($urandom_range(1, MAX_DIGITS));
            v.blen = 4'($urandom_range(1, MAX_DIGITS));
            v.a = 32'd0;
            v.b = 32'd0;
            for (int d = 0; d < int'(v.alen); d++) v.a[d*4 +: 4] = 4'($urandom_range(0, 9));
            for (int d = 0; d < int'(v.blen); d++) v.b[d*4 +: 4] = 4'($urandom_range(0, 9));
            v.op = 2'($urandom_range(0, 2));
            v.mode = 0;
            v.busy_len = $urandom_range(1, 30);
            v.exp_err = 1'b0;
            v.exp_res = arith(bcd_val(v.a, v.alen), bcd_val(v.b, v.blen), v.op);
            run_vec(v, 1'b1);
        end

        // Asynchronous reset while operand B is being keyed
        begin
            int found = 0;
            int loud = 0;
            model_mode = 0;
            model_busy_len = 5;
            op_a_bcd = 32'h12; op_a_len = 4'd2; op_b_bcd = 32'h34; op_b_len = 4'd2; op = 2'b00;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (cmd == 4'd3) begin
                    found = 1;
                    break;
                end
                @(negedge clock);
            end
            check("sendb_reached", 32'(found), 32'd1);
            #2 reset = 1'b0;
            #1;
            check("arst_cmd", 32'(cmd), 32'(CMD_NOP));
            check("arst_busy", 32'(busy), 32'd0);
            check("arst_done", 32'(done), 32'd0);
            check("arst_error", 32'(error), 32'd0);
            check("arst_result", result_q, 32'd0);
            @(negedge clock);
            reset = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (busy || cmd != CMD_NOP) loud++;
            end
            check("post_rst_quiet", 32'(loud), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
